// File: rtl/sdio_cmd_ctrl.sv
// Host-side SD/SDIO CMD line sequencer: sends a 48-bit command frame, then collects
// and checks the card response (none, short, long) and reports the outcome.
module sdio_cmd_ctrl #(
    parameter int MAXLAT    = 64,
    parameter int SHORT_LEN = 48,
    parameter int LONG_LEN  = 136
) (
    input  logic         sd_clk,
    input  logic         rst,
    input  logic         sd_en,
    input  logic         start_i,
    input  logic [5:0]   cmd_idx_i,
    input  logic [31:0]  arg_i,
    input  logic [1:0]   resp_type_i,
    input  logic         cmd_in_i,
    output logic         cmd_out_o,
    output logic         cmd_oe_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         timeout_o,
    output logic         crc_err_o,
    output logic [5:0]   resp_idx_o,
    output logic [119:0] resp_o
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SEND      = 3'd1;
    localparam logic [2:0] S_WAIT_RESP = 3'd2;
    localparam logic [2:0] S_RECV      = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    localparam int         LAT_W     = $clog2(MAXLAT + 1);
    localparam logic [7:0] SHORT_N   = 8'(SHORT_LEN);
    localparam logic [7:0] LONG_N    = 8'(LONG_LEN);
    // CRC windows in 1-based received-bit numbers (bit 1 = start bit)
    localparam logic [7:0] SHORT_CRC_LAST = 8'(SHORT_LEN - 8);
    localparam logic [7:0] LONG_CRC_FIRST = 8'(LONG_LEN - 127);
    localparam logic [7:0] LONG_CRC_LAST  = 8'(LONG_LEN - 8);

    logic [2:0]       state;
    logic [1:0]       rtype;
    logic [47:0]      tx_shift;
    logic [5:0]       tx_cnt;
    logic [LAT_W-1:0] lat_cnt;
    logic [7:0]       rx_cnt;
    logic [6:0]       rx_crc;
    logic [126:0]     rx_shift;

    logic [47:0]      cmd_frame;
    logic [7:0]       rx_num;
    logic [7:0]       frame_len;
    logic             rx_long;
    logic             crc_window;
    logic             crc_bad;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[6];
        return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
    endfunction

    function automatic logic [6:0] crc7_40(input logic [39:0] d);
        logic [6:0] c;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
        return c;
    endfunction

    always_comb begin
        cmd_frame  = {2'b01, cmd_idx_i, arg_i, crc7_40({2'b01, cmd_idx_i, arg_i}), 1'b1};
        rx_num     = rx_cnt + 8'd1;
        rx_long    = (rtype == 2'd2);
        frame_len  = rx_long ? LONG_N : SHORT_N;
        crc_window = rx_long ? (rx_num >= LONG_CRC_FIRST && rx_num <= LONG_CRC_LAST)
                             : (rx_num <= SHORT_CRC_LAST);
        // rx_shift still holds the previous bits, so [6:0] are frame bits 7..1 on the last bit
        crc_bad    = (rtype != 2'd3) && (rx_crc != rx_shift[6:0]);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge sd_clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            rtype      <= 2'd0;
            tx_shift   <= '0;
            tx_cnt     <= '0;
            lat_cnt    <= '0;
            rx_cnt     <= '0;
            rx_crc     <= '0;
            rx_shift   <= '0;
            cmd_out_o  <= 1'b1;
            cmd_oe_o   <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            timeout_o  <= 1'b0;
            crc_err_o  <= 1'b0;
            resp_idx_o <= '0;
            resp_o     <= '0;
        end else if (!sd_en) begin
            state     <= S_IDLE;
            cmd_out_o <= 1'b1;
            cmd_oe_o  <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    cmd_out_o <= 1'b1;
                    cmd_oe_o  <= 1'b0;
                    if (start_i) begin
                        rtype     <= resp_type_i;
                        cmd_out_o <= cmd_frame[47];
                        cmd_oe_o  <= 1'b1;
                        tx_shift  <= {cmd_frame[46:0], 1'b0};
                        tx_cnt    <= 6'd47;
                        busy_o    <= 1'b1;
                        timeout_o <= 1'b0;
                        crc_err_o <= 1'b0;
                        resp_o    <= '0;
                        state     <= S_SEND;
                    end
                end

                S_SEND: begin
                    if (tx_cnt == 6'd0) begin
                        cmd_out_o <= 1'b1;
                        cmd_oe_o  <= 1'b0;
                        lat_cnt   <= '0;
                        if (rtype == 2'd0) begin
                            done_o <= 1'b1;
                            busy_o <= 1'b0;
                            state  <= S_DONE;
                        end else begin
                            state <= S_WAIT_RESP;
                        end
                    end else begin
                        cmd_out_o <= tx_shift[47];
                        tx_shift  <= {tx_shift[46:0], 1'b0};
                        tx_cnt    <= tx_cnt - 6'd1;
                    end
                end

                S_WAIT_RESP: begin
                    if (!cmd_in_i) begin
                        // start bit is 0, so both the shift register and CRC start from zero
                        rx_cnt   <= 8'd1;
                        rx_crc   <= 7'd0;
                        rx_shift <= '0;
                        state    <= S_RECV;
                    end else if (lat_cnt == LAT_W'(MAXLAT - 1)) begin
                        timeout_o <= 1'b1;
                        done_o    <= 1'b1;
                        busy_o    <= 1'b0;
                        state     <= S_DONE;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end

                S_RECV: begin
                    rx_shift <= {rx_shift[125:0], cmd_in_i};
                    rx_cnt   <= rx_num;
                    if (crc_window) rx_crc <= crc7_step(rx_crc, cmd_in_i);
                    if (rx_num == frame_len) begin
                        crc_err_o <= !cmd_in_i || crc_bad;
                        if (rx_long) begin
                            resp_idx_o <= 6'h3F;
                            resp_o     <= rx_shift[126:7];
                        end else begin
                            resp_idx_o <= rx_shift[44:39];
                            resp_o     <= {88'd0, rx_shift[38:7]};
                        end
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= S_DONE;
                    end
                end

                S_DONE: state <= S_IDLE;

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdio_cmd_ctrl.sv
// Directed bench for sdio_cmd_ctrl: command serialisation, short/long responses,
// CRC and end-bit errors, timeout and both abort paths.
module tb_sdio_cmd_ctrl;

    logic         sd_clk = 1'b0;
    logic         rst;
    logic         sd_en;
    logic         start_i;
    logic [5:0]   cmd_idx_i;
    logic [31:0]  arg_i;
    logic [1:0]   resp_type_i;
    logic         cmd_in_i;
    logic         cmd_out_o;
    logic         cmd_oe_o;
    logic         busy_o;
    logic         done_o;
    logic         timeout_o;
    logic         crc_err_o;
    logic [5:0]   resp_idx_o;
    logic [119:0] resp_o;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    sdio_cmd_ctrl dut (
        .sd_clk      (sd_clk),
        .rst         (rst),
        .sd_en       (sd_en),
        .start_i     (start_i),
        .cmd_idx_i   (cmd_idx_i),
        .arg_i       (arg_i),
        .resp_type_i (resp_type_i),
        .cmd_in_i    (cmd_in_i),
        .cmd_out_o   (cmd_out_o),
        .cmd_oe_o    (cmd_oe_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .timeout_o   (timeout_o),
        .crc_err_o   (crc_err_o),
        .resp_idx_o  (resp_idx_o),
        .resp_o      (resp_o)
    );

    always #5 sd_clk = ~sd_clk;

    always @(posedge sd_clk) if (done_o) done_cnt++;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Long division by x^7+x^3+1 over the 120-bit message, remainder is the CRC.
    function automatic logic [6:0] ref_crc120(input logic [119:0] msg);
        logic [126:0] m;
        m = {msg, 7'd0};
        for (int i = 126; i >= 7; i--)
            if (m[i]) m[i -: 8] = m[i -: 8] ^ 8'h89;
        return m[6:0];
    endfunction

    // Issues a command and captures the 48 bits seen on cmd_out_o (cycles 1..48).
    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                            output logic [47:0] frame, output int oe_cycles);
        @(negedge sd_clk);
        cmd_idx_i = idx; arg_i = arg; resp_type_i = rt; start_i = 1'b1;
        @(negedge sd_clk);
        start_i = 1'b0;
        frame = '0;
        oe_cycles = 0;
        for (int k = 0; k < 48; k++) begin
            if (k > 0) @(negedge sd_clk);
            frame = {frame[46:0], cmd_out_o};
            if (cmd_oe_o) oe_cycles++;
        end
    endtask

    // Card side: idle-high gap, then len bits MSB first; returns on the cycle after the last bit.
    task automatic card_reply(input logic [135:0] bits, input int len, input int gap);
        for (int g = 0; g < gap; g++) begin
            @(negedge sd_clk);
            cmd_in_i = 1'b1;
        end
        for (int i = len - 1; i >= 0; i--) begin
            @(negedge sd_clk);
            cmd_in_i = bits[i];
        end
        @(negedge sd_clk);
        cmd_in_i = 1'b1;
    endtask

    task automatic wait_done(input int limit, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge sd_clk);
            if (done_o) seen = 1'b1;
        end
    endtask

    logic [47:0]  frame;
    int           oe_cycles;
    int           d0;
    logic         seen;
    logic [119:0] cid;
    logic [135:0] long_bits;

    initial begin
        rst = 1'b0; sd_en = 1'b1; start_i = 1'b0; cmd_in_i = 1'b1;
        cmd_idx_i = '0; arg_i = '0; resp_type_i = '0;
        repeat (3) @(negedge sd_clk);
        chk("rst_cmd_out", cmd_out_o, 1'b1);
        chk("rst_cmd_oe", cmd_oe_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_timeout", timeout_o, 1'b0);
        chk("rst_crc_err", crc_err_o, 1'b0);
        chk("rst_resp_idx", resp_idx_o, 6'd0);
        chk("rst_resp", resp_o, 120'd0);
        rst = 1'b1;
        repeat (2) @(negedge sd_clk);

        // CMD0, no response
        d0 = done_cnt;
        send_cmd(6'd0, 32'h0, 2'd0, frame, oe_cycles);
        chk("cmd0_frame", frame, 48'h400000000095);
        chk("cmd0_oe_cycles", oe_cycles, 48);
        chk("cmd0_busy_in_send", busy_o, 1'b1);
        @(negedge sd_clk);
        chk("cmd0_done_c49", done_o, 1'b1);
        chk("cmd0_oe_off_c49", cmd_oe_o, 1'b0);
        chk("cmd0_busy_c49", busy_o, 1'b0);
        chk("cmd0_timeout", timeout_o, 1'b0);
        chk("cmd0_crc_err", crc_err_o, 1'b0);
        // start_i raised during DONE is ignored, then taken in the following IDLE cycle
        cmd_idx_i = 6'd0; arg_i = 32'h0; resp_type_i = 2'd0; start_i = 1'b1;
        @(negedge sd_clk);
        chk("start_in_done_ignored", busy_o, 1'b0);
        @(negedge sd_clk);
        start_i = 1'b0;
        chk("start_in_idle_taken", busy_o, 1'b1);
        wait_done(60, seen);
        chk("cmd0_again_done", seen, 1'b1);
        repeat (2) @(negedge sd_clk);
        chk("cmd0_done_pulses", done_cnt - d0, 2);

        // CMD8 with R7 short response
        d0 = done_cnt;
        send_cmd(6'd8, 32'h000001AA, 2'd1, frame, oe_cycles);
        chk("cmd8_frame", frame, 48'h48000001AA87);
        card_reply(136'h08000001AA13, 48, 5);
        chk("cmd8_done", done_o, 1'b1);
        chk("cmd8_resp_idx", resp_idx_o, 6'd8);
        chk("cmd8_resp", resp_o, 120'h1AA);
        chk("cmd8_crc_err", crc_err_o, 1'b0);
        chk("cmd8_timeout", timeout_o, 1'b0);
        @(negedge sd_clk);
        chk("cmd8_done_one_cycle", done_o, 1'b0);
        chk("cmd8_done_pulses", done_cnt - d0, 1);

        // response CRC bit flipped
        d0 = done_cnt;
        send_cmd(6'd8, 32'h000001AA, 2'd1, frame, oe_cycles);
        card_reply(136'h08000001AA17, 48, 5);
        chk("crcflip_done", done_o, 1'b1);
        chk("crcflip_crc_err", crc_err_o, 1'b1);
        @(negedge sd_clk);
        chk("crcflip_done_pulses", done_cnt - d0, 1);

        // end bit 0
        d0 = done_cnt;
        send_cmd(6'd8, 32'h000001AA, 2'd1, frame, oe_cycles);
        card_reply(136'h08000001AA12, 48, 5);
        chk("endbit_done", done_o, 1'b1);
        chk("endbit_crc_err", crc_err_o, 1'b1);
        @(negedge sd_clk);
        chk("endbit_done_pulses", done_cnt - d0, 1);

        // CMD2 with no card answer: 64 wait cycles then timeout
        d0 = done_cnt;
        send_cmd(6'd2, 32'h0, 2'd2, frame, oe_cycles);
        repeat (64) @(negedge sd_clk);
        chk("tmo_not_yet", done_o, 1'b0);
        chk("tmo_busy_waiting", busy_o, 1'b1);
        @(negedge sd_clk);
        chk("tmo_done", done_o, 1'b1);
        chk("tmo_timeout", timeout_o, 1'b1);
        chk("tmo_resp_cleared", resp_o, 120'd0);
        chk("tmo_crc_err", crc_err_o, 1'b0);
        repeat (2) @(negedge sd_clk);
        chk("tmo_done_pulses", done_cnt - d0, 1);

        // CMD2 with a valid 136-bit CID
        cid = 120'h0353445344313647801234567890AB;
        long_bits = {8'h3F, cid, ref_crc120(cid), 1'b1};
        send_cmd(6'd2, 32'h0, 2'd2, frame, oe_cycles);
        card_reply(long_bits, 136, 3);
        chk("cid_done", done_o, 1'b1);
        chk("cid_resp_idx", resp_idx_o, 6'h3F);
        chk("cid_resp", resp_o, cid);
        chk("cid_crc_err", crc_err_o, 1'b0);
        chk("cid_timeout", timeout_o, 1'b0);

        // async reset in the middle of SEND
        @(negedge sd_clk);
        cmd_idx_i = 6'd8; arg_i = 32'h000001AA; resp_type_i = 2'd1; start_i = 1'b1;
        @(negedge sd_clk);
        start_i = 1'b0;
        repeat (20) @(negedge sd_clk);
        chk("rstab_sending", cmd_oe_o, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("rstab_oe", cmd_oe_o, 1'b0);
        chk("rstab_out", cmd_out_o, 1'b1);
        chk("rstab_busy", busy_o, 1'b0);
        @(negedge sd_clk);
        rst = 1'b1;
        d0 = done_cnt;
        send_cmd(6'd0, 32'h0, 2'd0, frame, oe_cycles);
        chk("rstab_new_frame", frame, 48'h400000000095);
        wait_done(4, seen);
        chk("rstab_new_done", seen, 1'b1);

        // sd_en dropped in the middle of RECV
        send_cmd(6'd8, 32'h000001AA, 2'd1, frame, oe_cycles);
        d0 = done_cnt;
        for (int i = 0; i < 2; i++) begin
            @(negedge sd_clk);
            cmd_in_i = 1'b1;
        end
        for (int i = 47; i >= 28; i--) begin
            @(negedge sd_clk);
            cmd_in_i = frame[i] ^ (i == 46);  // card frame 0x08..., transmission bit clear
        end
        @(negedge sd_clk);
        chk("enab_busy_before", busy_o, 1'b1);
        sd_en = 1'b0;
        cmd_in_i = 1'b1;
        @(negedge sd_clk);
        chk("enab_busy", busy_o, 1'b0);
        chk("enab_oe", cmd_oe_o, 1'b0);
        chk("enab_out", cmd_out_o, 1'b1);
        repeat (40) @(negedge sd_clk);
        chk("enab_no_done", done_cnt - d0, 0);
        sd_en = 1'b1;
        send_cmd(6'd8, 32'h000001AA, 2'd1, frame, oe_cycles);
        chk("enab_new_frame", frame, 48'h48000001AA87);
        card_reply(136'h08000001AA13, 48, 2);
        chk("enab_new_done", done_o, 1'b1);
        chk("enab_new_resp", resp_o, 120'h1AA);
        chk("enab_new_crc_err", crc_err_o, 1'b0);

        repeat (2) @(negedge sd_clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
